pixel_streamer: RTL and testbench

- Raster-order RGB pixel source that feeds the image filter's pixel input (drives its data_in_valid / data_in).
- Reads a frame from a synchronous-read frame buffer (1-cycle read latency) and emits one packed RGB pixel per enabled cycle with x/y coordinates.
- Optional per-line blanking gap.
- Gated by the filter controller's process_enable, so pixels are only sent once weights are loaded.

---
 rtl/pixel_streamer_pkg.sv | 29 ++
 rtl/pixel_streamer_raster_counter.sv | 73 +++++++
 rtl/pixel_streamer.sv | 154 +++++++++++++++
 tb/tb_pixel_streamer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_streamer_pkg.sv
// Shared definitions for the raster pixel streamer: FSM encoding and width helpers.
package pixel_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        BLANK  = 2'd2
    } state_e;

    localparam int NUM_CHANNELS = 3;

    // Ceiling log2, floored at 1 so degenerate sizes still yield a usable bus.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int pix_w(input int bitwidth);
        return NUM_CHANNELS * bitwidth;
    endfunction

endpackage

// File: rtl/pixel_streamer_raster_counter.sv
// Column/row/linear-address counters for raster scan; the address is kept incrementally.
module raster_counter
    import pixel_streamer_pkg::*;
#(
    parameter int COLS   = 640,
    parameter int ROWS   = 480,
    parameter int ADDR_W = clog2(COLS * ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    output logic [clog2(COLS):0]  col,
    output logic [clog2(ROWS):0]  row,
    output logic [ADDR_W-1:0]     addr,
    output logic                  line_end,
    output logic                  frame_end
);

    localparam int XW = clog2(COLS) + 1;
    localparam int YW = clog2(ROWS) + 1;

    logic [XW-1:0]     col_q, col_d;
    logic [YW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign line_end  = (col_q == XW'(COLS - 1));
    assign frame_end = line_end && (row_q == YW'(ROWS - 1));

    // NOTE: every always_comb output gets its hold value first so no path can infer a latch.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (en) begin
            if (line_end) begin
                col_d = '0;
                if (frame_end) begin
                    row_d  = '0;
                    addr_d = '0;
                end else begin
                    row_d  = row_q + YW'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end else begin
                col_d  = col_q + XW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = addr_q;

endmodule

// File: rtl/pixel_streamer.sv
// Raster-order RGB pixel source: reads a frame buffer and emits pixels with x/y, gated by process_enable.
module pixel_streamer
    import pixel_streamer_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int COLS     = 640,
    parameter int ROWS     = 480,
    parameter int HBLANK   = 0,
    parameter int ADDR_W   = clog2(COLS * ROWS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         process_enable,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [pix_w(BITWIDTH)-1:0]   mem_rdata,
    output logic                         data_valid,
    output logic [pix_w(BITWIDTH)-1:0]   data_out,
    output logic [clog2(COLS):0]         x,
    output logic [clog2(ROWS):0]         y,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int PW = pix_w(BITWIDTH);
    localparam int XW = clog2(COLS) + 1;
    localparam int YW = clog2(ROWS) + 1;
    localparam int BW = clog2(HBLANK + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

    state_e        state_q, state_d;
    logic [BW-1:0] blank_q, blank_d;

    logic          rd_en;
    logic          cnt_clear;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          line_end;
    logic          frame_end;

    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [PW-1:0] hold_q, hold_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    raster_counter #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_raster_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .en        (rd_en),
        .col       (col),
        .row       (row),
        .addr      (mem_addr),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    always_comb begin
        state_d   = state_q;
        blank_d   = blank_q;
        rd_en     = 1'b0;
        cnt_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = STREAM;
                    cnt_clear = 1'b1;
                end
            end
            STREAM: begin
                if (process_enable) begin
                    rd_en = 1'b1;
                    if (line_end) begin
                        if (frame_end) begin
                            state_d = IDLE;
                        end else if (HBLANK > 0) begin
                            state_d = BLANK;
                            blank_d = '0;
                        end
                    end
                end
            end
            BLANK: begin
                // The gap runs on its own clock count; the filter's readiness does not stretch it.
                if (blank_q == BLANK_LAST) begin
                    state_d = STREAM;
                end else begin
                    blank_d = blank_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything above, including a same-cycle start or issue.
        if (abort) begin
            state_d   = IDLE;
            blank_d   = '0;
            rd_en     = 1'b0;
            cnt_clear = 1'b1;
        end
    end

    always_comb begin
        valid_d = rd_en;
        done_d  = rd_en && frame_end;
        x_d     = x_q;
        y_d     = y_q;
        hold_d  = hold_q;
        if (rd_en) begin
            x_d = col;
            y_d = row;
        end
        if (valid_q) begin
            hold_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            blank_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Read data arrives straight from the buffer on the valid cycle; the hold register covers idle cycles.
    assign data_out   = valid_q ? mem_rdata : hold_q;
    assign data_valid = valid_q;
    assign frame_done = done_q;
    assign x          = x_q;
    assign y          = y_q;
    assign mem_rd_en  = rd_en;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer on a 4x3 frame with a 2-cycle line gap.
module tb_pixel_streamer;

    localparam int COLS   = 4;
    localparam int ROWS   = 3;
    localparam int HBLANK = 2;
    localparam int NPIX   = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        process_enable = 1'b0;
    logic        mem_rd_en;
    logic [3:0]  mem_addr;
    logic [23:0] mem_rdata = '0;
    logic        data_valid;
    logic [23:0] data_out;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        busy;
    logic        frame_done;

    pixel_streamer #(
        .BITWIDTH (8),
        .COLS     (COLS),
        .ROWS     (ROWS),
        .HBLANK   (HBLANK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .process_enable (process_enable),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .data_valid     (data_valid),
        .data_out       (data_out),
        .x              (x),
        .y              (y),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame buffer model: mem[a] = {a, a+1, a+2}, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rdata <= {8'(int'(mem_addr)), 8'(int'(mem_addr) + 1), 8'(int'(mem_addr) + 2)};
    end

    typedef struct {
        logic [23:0] data;
        logic [2:0]  x;
        logic [2:0]  y;
        logic        fd;
        int          cyc;
    } pix_t;

    pix_t v_q[$];
    int   iss_cnt = 0;
    int   bad_issue = 0;
    int   fd_cnt = 0;
    int   stray_fd = 0;

    always @(negedge clk) begin
        if (data_valid) v_q.push_back('{data_out, x, y, frame_done, cyc});
        if (mem_rd_en) begin
            iss_cnt++;
            if (!process_enable) bad_issue++;
        end
        if (frame_done) begin
            fd_cnt++;
            if (!data_valid) stray_fd++;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int start_cyc = 0;

    // Reference: pixel k of a frame sits at (k mod COLS, k div COLS) and carries mem[k].
    function automatic pix_t exp_pix(input int k);
        pix_t p;
        p.data = {8'(k), 8'(k + 1), 8'(k + 2)};
        p.x    = 3'(k % COLS);
        p.y    = 3'(k / COLS);
        p.fd   = (k == NPIX - 1);
        p.cyc  = 0;
        return p;
    endfunction

    function automatic int first_bad();
        pix_t e;
        for (int k = 0; k < v_q.size() && k < NPIX; k++) begin
            e = exp_pix(k);
            if (v_q[k].data !== e.data || v_q[k].x !== e.x || v_q[k].y !== e.y || v_q[k].fd !== e.fd)
                return k;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        v_q.delete();
        iss_cnt = 0;
        bad_issue = 0;
        fd_cnt = 0;
        stray_fd = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pixels(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (v_q.size() >= n) break;
            tick();
        end
        repeat (6) tick();
    endtask

    task automatic wait_issues(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (iss_cnt >= n) break;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [47:0] outs;
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
            process_enable = 1'($urandom_range(0, 1));
            tick();
            outs = {mem_rd_en, mem_addr, data_valid, data_out, x, y, busy, frame_done, 11'd0};
            n_chk++;
            if (outs !== '0) $display("FAIL reset_outputs cycle %0d: got %h want 0", i, outs);
            else n_pass++;
        end
        start = 1'b0;
        abort = 1'b0;
        process_enable = 1'b1;
        rst = 1'b1;
        clear_rec();
        repeat (10) tick();
        n_chk++;
        if (iss_cnt !== 0 || busy !== 1'b0) $display("FAIL idle_no_reads: reads=%0d busy=%b want 0/0", iss_cnt, busy);
        else n_pass++;
    endtask

    task automatic test_full_frame();
        int kb;
        int gbad;
        int first;
        int want_gap;
        clear_rec();
        process_enable = 1'b1;
        pulse_start();
        wait_pixels(NPIX, 60);
        n_chk++;
        if (v_q.size() !== NPIX) $display("FAIL full_count: got %0d want %0d", v_q.size(), NPIX);
        else n_pass++;
        kb = first_bad();
        n_chk++;
        if (kb != -1) $display("FAIL full_pixel %0d: got data=%h x=%0d y=%0d fd=%b", kb, v_q[kb].data, v_q[kb].x, v_q[kb].y, v_q[kb].fd);
        else n_pass++;
        first = (v_q.size() > 0) ? v_q[0].cyc : -1;
        n_chk++;
        if (first != start_cyc + 2) $display("FAIL first_latency: got cycle %0d want %0d", first, start_cyc + 2);
        else n_pass++;
        gbad = -1;
        for (int k = 1; k < v_q.size(); k++) begin
            want_gap = (k % COLS == 0) ? HBLANK + 1 : 1;
            if (v_q[k].cyc - v_q[k-1].cyc != want_gap && gbad == -1) gbad = k;
        end
        n_chk++;
        if (gbad != -1) $display("FAIL line_gap at pixel %0d: got spacing %0d", gbad, v_q[gbad].cyc - v_q[gbad-1].cyc);
        else n_pass++;
        n_chk++;
        if (fd_cnt !== 1 || stray_fd !== 0) $display("FAIL frame_done_once: got %0d pulses (%0d stray) want 1/0", fd_cnt, stray_fd);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL busy_after_frame: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_enable_gap();
        int kb;
        int resume_cyc;
        clear_rec();
        process_enable = 1'b1;
        pulse_start();
        wait_issues(6, 40);
        process_enable = 1'b0;
        repeat (3) tick();
        n_chk++;
        if (iss_cnt !== 6 || v_q.size() !== 6) $display("FAIL enable_gap_hold: got reads=%0d valids=%0d want 6/6", iss_cnt, v_q.size());
        else n_pass++;
        resume_cyc = cyc;
        process_enable = 1'b1;
        wait_pixels(NPIX, 60);
        n_chk++;
        if (v_q.size() < 7 || v_q[6].cyc != resume_cyc + 1) $display("FAIL enable_resume_timing: got %0d pixels, want pixel 6 at cycle %0d", v_q.size(), resume_cyc + 1);
        else n_pass++;
        n_chk++;
        if (v_q.size() !== NPIX) $display("FAIL enable_count: got %0d want %0d", v_q.size(), NPIX);
        else n_pass++;
        kb = first_bad();
        n_chk++;
        if (kb != -1) $display("FAIL enable_pixel %0d: got data=%h x=%0d y=%0d", kb, v_q[kb].data, v_q[kb].x, v_q[kb].y);
        else n_pass++;
    endtask

    task automatic test_random_enable();
        int kb;
        for (int f = 0; f < 3; f++) begin
            clear_rec();
            process_enable = 1'($urandom_range(0, 1));
            pulse_start();
            for (int i = 0; i < 300; i++) begin
                if (v_q.size() >= NPIX) break;
                process_enable = 1'($urandom_range(0, 1));
                tick();
            end
            process_enable = 1'b1;
            wait_pixels(NPIX, 60);
            kb = first_bad();
            n_chk++;
            if (v_q.size() !== NPIX || kb != -1 || bad_issue !== 0 || fd_cnt !== 1)
                $display("FAIL random_enable frame %0d: got count=%0d first_bad=%0d gated_reads=%0d done=%0d", f, v_q.size(), kb, bad_issue, fd_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        int kb;
        clear_rec();
        process_enable = 1'b1;
        pulse_start();
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pixels(NPIX, 60);
        kb = first_bad();
        n_chk++;
        if (v_q.size() !== NPIX || kb != -1) $display("FAIL start_while_busy: got count=%0d first_bad=%0d", v_q.size(), kb);
        else n_pass++;

        clear_rec();
        process_enable = 1'b0;
        pulse_start();
        repeat (5) tick();
        n_chk++;
        if (busy !== 1'b1 || iss_cnt !== 0 || v_q.size() !== 0) $display("FAIL start_gated: got busy=%b reads=%0d valids=%0d want 1/0/0", busy, iss_cnt, v_q.size());
        else n_pass++;
        process_enable = 1'b1;
        wait_pixels(NPIX, 60);
        kb = first_bad();
        n_chk++;
        if (v_q.size() !== NPIX || kb != -1) $display("FAIL start_gated_frame: got count=%0d first_bad=%0d", v_q.size(), kb);
        else n_pass++;
    endtask

    task automatic test_abort();
        int kb;
        clear_rec();
        process_enable = 1'b1;
        pulse_start();
        wait_issues(7, 40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) $display("FAIL abort_next: got valid=%b busy=%b rd=%b want 0/0/0", data_valid, busy, mem_rd_en);
        else n_pass++;
        repeat (8) tick();
        n_chk++;
        if (v_q.size() !== 7 || fd_cnt !== 0) $display("FAIL abort_quiet: got valids=%0d done=%0d want 7/0", v_q.size(), fd_cnt);
        else n_pass++;

        clear_rec();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (5) tick();
        n_chk++;
        if (busy !== 1'b0 || iss_cnt !== 0) $display("FAIL abort_beats_start: got busy=%b reads=%0d want 0/0", busy, iss_cnt);
        else n_pass++;

        clear_rec();
        pulse_start();
        wait_pixels(NPIX, 60);
        kb = first_bad();
        n_chk++;
        if (v_q.size() !== NPIX || kb != -1) $display("FAIL abort_restart: got count=%0d first_bad=%0d", v_q.size(), kb);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int kb;
        logic [47:0] outs;
        clear_rec();
        process_enable = 1'b1;
        pulse_start();
        wait_issues(6, 40);
        rst = 1'b0;
        #1;
        outs = {mem_rd_en, mem_addr, data_valid, data_out, x, y, busy, frame_done, 11'd0};
        n_chk++;
        if (outs !== '0) $display("FAIL reset_mid_outputs: got %h want 0", outs);
        else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        clear_rec();
        pulse_start();
        wait_pixels(NPIX, 60);
        kb = first_bad();
        n_chk++;
        if (v_q.size() !== NPIX || kb != -1 || fd_cnt !== 1) $display("FAIL reset_mid_frame: got count=%0d first_bad=%0d done=%0d", v_q.size(), kb, fd_cnt);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_enable_gap();
        test_random_enable();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
